// File: rtl/rv32_dmem_arbiter.sv
// Data-side RAM port arbiter between the CPU MEM stage (port C) and the loader/DMA (port L).
// One grant per cycle, loader bursts, and a starvation guard that lets the loader override the CPU.
module rv32_dmem_arbiter #(
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,

    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [3:0]  ldr_be,
    input  logic [31:0] ldr_addr,
    input  logic [31:0] ldr_wdata,
    input  logic        ldr_burst,
    output logic        ldr_gnt,
    output logic        ldr_rvalid,
    output logic [31:0] ldr_rdata,

    output logic [31:0] memif_addr,
    output logic        memif_we,
    output logic [3:0]  memif_be,
    output logic [31:0] memif_wdata,
    input  logic [31:0] memif_rdata
);

    localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned BeatW = $clog2(BURST_MAX + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
    localparam logic [BeatW-1:0] BeatMax = BeatW'(BURST_MAX);

    typedef enum logic [0:0] {StArb, StBurst} state_e;

    state_e            state_q;
    logic [WaitW-1:0]  wait_cnt_q;
    logic [BeatW-1:0]  beat_cnt_q;
    logic [BeatW-1:0]  beat_inc;
    logic              rd_owner_c_q;
    logic              rd_owner_l_q;
    logic [31:0]       addr_q;
    logic              override;

    // Loader has waited long enough to take the RAM from the CPU.
    assign override = ldr_req && (wait_cnt_q == WaitMax);
    assign beat_inc = beat_cnt_q + 1'b1;

    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        if (reset) begin
            if (state_q == StBurst) begin
                ldr_gnt = ldr_req;
            end else if (cpu_req && !override) begin
                cpu_gnt = 1'b1;
            end else if (ldr_req) begin
                ldr_gnt = 1'b1;
            end
        end
    end

    // Idle cycles keep the last address on the bus to avoid needless toggling.
    always_comb begin
        memif_addr  = addr_q;
        memif_we    = 1'b0;
        memif_be    = 4'b0000;
        memif_wdata = 32'h0;
        if (cpu_gnt) begin
            memif_addr  = cpu_addr;
            memif_we    = cpu_we;
            memif_be    = cpu_be;
            memif_wdata = cpu_wdata;
        end else if (ldr_gnt) begin
            memif_addr  = ldr_addr;
            memif_we    = ldr_we;
            memif_be    = ldr_be;
            memif_wdata = ldr_wdata;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rvalid = rd_owner_c_q;
    assign ldr_rvalid = rd_owner_l_q;
    assign cpu_rdata  = rd_owner_c_q ? memif_rdata : 32'h0;
    assign ldr_rdata  = rd_owner_l_q ? memif_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StArb;
            wait_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            rd_owner_c_q <= 1'b0;
            rd_owner_l_q <= 1'b0;
            addr_q       <= 32'h0;
        end else begin
            addr_q       <= memif_addr;
            rd_owner_c_q <= cpu_gnt & ~cpu_we;
            rd_owner_l_q <= ldr_gnt & ~ldr_we;

            if (ldr_gnt) begin
                wait_cnt_q <= '0;
            end else if (ldr_req && (wait_cnt_q != WaitMax)) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end

            if (state_q == StArb) begin
                if (ldr_gnt && ldr_burst && (BURST_MAX > 1)) begin
                    state_q    <= StBurst;
                    beat_cnt_q <= BeatW'(1);
                end
            end else if (!ldr_req) begin
                state_q    <= StArb;
                beat_cnt_q <= '0;
            end else if ((beat_inc == BeatMax) || !ldr_burst) begin
                // This beat is the last one of the burst.
                state_q    <= StArb;
                beat_cnt_q <= '0;
            end else begin
                beat_cnt_q <= beat_inc;
            end
        end
    end

endmodule

// File: tb/tb_rv32_dmem_arbiter.sv
// Bench for rv32_dmem_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration rules and a golden word memory.
module tb_rv32_dmem_arbiter;

    localparam int unsigned MAX_WAIT  = 8;
    localparam int unsigned BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ldr_req, ldr_we, ldr_burst;
    logic [3:0]  ldr_be;
    logic [31:0] ldr_addr, ldr_wdata;
    logic        ldr_gnt, ldr_rvalid;
    logic [31:0] ldr_rdata;
    logic [31:0] memif_addr, memif_wdata, memif_rdata;
    logic        memif_we;
    logic [3:0]  memif_be;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram  [256];
    logic [31:0] gold [256];

    bit          m_burst;
    int          m_beats;
    int          m_waits;
    bit          m_rv_c, m_rv_l;
    logic [31:0] m_rd_c, m_rd_l;

    rv32_dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_burst(ldr_burst), .ldr_gnt(ldr_gnt),
        .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .memif_addr(memif_addr), .memif_we(memif_we), .memif_be(memif_be),
        .memif_wdata(memif_wdata), .memif_rdata(memif_rdata)
    );

    always #5 clk = ~clk;

    // Who should own the RAM this cycle, from the arbitration rules and model state.
    function automatic void predict(output bit cg, output bit lg);
        cg = 1'b0;
        lg = 1'b0;
        if (reset === 1'b1) begin
            if (m_burst) lg = (ldr_req === 1'b1);
            else if (cpu_req === 1'b1 && !(ldr_req === 1'b1 && m_waits >= MAX_WAIT)) cg = 1'b1;
            else if (ldr_req === 1'b1) lg = 1'b1;
        end
    endfunction

    // RAM environment (driven by the DUT's bus) and the reference model (driven by requests).
    always @(posedge clk) begin : model
        bit          cg, lg;
        logic [31:0] rd;
        rd = ram[memif_addr[9:2]];
        if (memif_we === 1'b1)
            for (int b = 0; b < 4; b++)
                if (memif_be[b]) ram[memif_addr[9:2]][8*b +: 8] = memif_wdata[8*b +: 8];
        memif_rdata <= rd;

        predict(cg, lg);
        if (reset !== 1'b1) begin
            m_burst = 1'b0;
            m_beats = 0;
            m_waits = 0;
            m_rv_c  = 1'b0;
            m_rv_l  = 1'b0;
        end else begin
            m_rv_c = cg && !cpu_we;
            m_rv_l = lg && !ldr_we;
            if (m_rv_c) m_rd_c = gold[cpu_addr[9:2]];
            if (m_rv_l) m_rd_l = gold[ldr_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (cg && cpu_we && cpu_be[b]) gold[cpu_addr[9:2]][8*b +: 8] = cpu_wdata[8*b +: 8];
                if (lg && ldr_we && ldr_be[b]) gold[ldr_addr[9:2]][8*b +: 8] = ldr_wdata[8*b +: 8];
            end
            if (lg) m_waits = 0;
            else if (ldr_req && m_waits < MAX_WAIT) m_waits++;
            if (!m_burst) begin
                if (lg && ldr_burst && BURST_MAX > 1) begin
                    m_burst = 1'b1;
                    m_beats = 1;
                end
            end else if (!ldr_req) begin
                m_burst = 1'b0;
            end else begin
                m_beats++;
                if (m_beats == BURST_MAX || !ldr_burst) m_burst = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h0; cpu_wdata = $urandom;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_be = 4'hF; ldr_addr = 32'h4; ldr_wdata = $urandom;
        ldr_burst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_gnt !== 1'b0 || ldr_gnt !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt: cpu_gnt=%b ldr_gnt=%b, want 0 0", cpu_gnt, ldr_gnt);
            end
            checks++;
            if (memif_we !== 1'b0) begin
                errors++;
                $display("FAIL reset_we: memif_we=%b, want 0", memif_we);
            end
            checks++;
            if (cpu_rvalid !== 1'b0 || ldr_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_rvalid: %b %b, want 0 0", cpu_rvalid, ldr_rvalid);
            end
        end
        next_cycle();
        reset = 1'b1;
        cpu_we = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin
            errors++;
            $display("FAIL release_gnt: cpu_gnt=%b ldr_gnt=%b, want 1 0", cpu_gnt, ldr_gnt);
        end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ldr_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== m_rd_c) begin
            errors++;
            $display("FAIL release_next: ldr_gnt=%b cpu_rvalid=%b rdata=%h, want 1 1 %h",
                     ldr_gnt, cpu_rvalid, cpu_rdata, m_rd_c);
        end
        next_cycle();
        ldr_req = 1'b0;
    endtask

    task automatic test_cpu_read();
        logic [31:0] exp;
        exp = gold[16];
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || memif_addr !== 32'h40 || memif_we !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_issue: gnt=%b addr=%h we=%b stall=%b, want 1 00000040 0 0",
                     cpu_gnt, memif_addr, memif_we, cpu_stall);
        end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_data: rvalid=%b rdata=%h stall=%b, want 1 %h 0",
                     cpu_rvalid, cpu_rdata, cpu_stall, exp);
        end
        next_cycle();
    endtask

    task automatic test_conflict();
        bit exp_cg;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = $urandom & 32'h3FC;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_burst = 1'b0; ldr_be = 4'hF;
        ldr_addr = $urandom & 32'h3FC; ldr_wdata = $urandom;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp_cg = (i != MAX_WAIT + 1);
            checks++;
            if (cpu_gnt !== exp_cg || ldr_gnt !== !exp_cg || cpu_stall !== !exp_cg) begin
                errors++;
                $display("FAIL conflict_gnt[%0d]: cpu=%b ldr=%b stall=%b, want %b %b %b",
                         i, cpu_gnt, ldr_gnt, cpu_stall, exp_cg, !exp_cg, !exp_cg);
            end
            checks++;
            if (memif_addr !== (exp_cg ? cpu_addr : ldr_addr) || memif_we !== !exp_cg) begin
                errors++;
                $display("FAIL conflict_bus[%0d]: addr=%h we=%b, want %h %b", i, memif_addr,
                         memif_we, exp_cg ? cpu_addr : ldr_addr, !exp_cg);
            end
            checks++;
            if (cpu_rvalid !== m_rv_c || (m_rv_c && cpu_rdata !== m_rd_c)) begin
                errors++;
                $display("FAIL conflict_rdata[%0d]: rvalid=%b rdata=%h, want %b %h", i,
                         cpu_rvalid, cpu_rdata, m_rv_c, m_rd_c);
            end
            next_cycle();
            if (exp_cg) cpu_addr = $urandom & 32'h3FC;
            else begin
                ldr_addr = $urandom & 32'h3FC;
                ldr_wdata = $urandom;
            end
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_burst();
        logic [31:0] d [4];
        for (int k = 0; k < 4; k++) d[k] = $urandom;
        cpu_req = 1'b0;
        ldr_req = 1'b1; ldr_burst = 1'b1; ldr_we = 1'b1; ldr_be = 4'hF;
        ldr_addr = 32'h100; ldr_wdata = d[0];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (ldr_gnt !== 1'b1 || cpu_gnt !== 1'b0 || memif_we !== 1'b1 ||
                    memif_addr !== 32'h100 + 32'(4 * k) || memif_wdata !== d[k]) begin
                    errors++;
                    $display("FAIL burst_beat[%0d]: ldr=%b cpu=%b we=%b addr=%h wdata=%h, want 1 0 1 %h %h",
                             k, ldr_gnt, cpu_gnt, memif_we, memif_addr, memif_wdata,
                             32'h100 + 32'(4 * k), d[k]);
                end
                checks++;
                if (cpu_stall !== (k >= 2)) begin
                    errors++;
                    $display("FAIL burst_stall[%0d]: stall=%b, want %b", k, cpu_stall, k >= 2);
                end
            end else if (k == 4) begin
                checks++;
                if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_after: cpu=%b ldr=%b stall=%b, want 1 0 0",
                             cpu_gnt, ldr_gnt, cpu_stall);
                end
            end else begin
                checks++;
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== d[1] || ldr_gnt !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_readback: rvalid=%b rdata=%h ldr=%b, want 1 %h 1",
                             cpu_rvalid, cpu_rdata, ldr_gnt, d[1]);
                end
            end
            next_cycle();
            if (k < 3) begin
                ldr_addr = ldr_addr + 32'h4;
                ldr_wdata = d[k+1];
            end
            if (k == 1) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104;
            end
            if (k == 3) begin
                ldr_addr = 32'h110;
                ldr_wdata = $urandom;
            end
            if (k == 4) begin
                cpu_req = 1'b0;
                ldr_burst = 1'b0;
            end
        end
        ldr_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_early_end();
        logic [31:0] a0;
        logic [31:0] e0;
        a0 = $urandom & 32'h3FC;
        e0 = gold[a0[9:2]];
        cpu_req = 1'b0;
        ldr_req = 1'b1; ldr_burst = 1'b1; ldr_we = 1'b0; ldr_addr = a0;
        @(negedge clk);
        checks++;
        if (ldr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL early_beat1: ldr_gnt=%b, want 1", ldr_gnt);
        end
        next_cycle();
        ldr_addr = $urandom & 32'h3FC; ldr_burst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF;
        cpu_addr = $urandom & 32'h3FC; cpu_wdata = $urandom;
        @(negedge clk);
        checks++;
        if (ldr_gnt !== 1'b1 || cpu_stall !== 1'b1 || ldr_rvalid !== 1'b1 || ldr_rdata !== e0) begin
            errors++;
            $display("FAIL early_beat2: ldr=%b stall=%b rvalid=%b rdata=%h, want 1 1 1 %h",
                     ldr_gnt, cpu_stall, ldr_rvalid, ldr_rdata, e0);
        end
        next_cycle();
        ldr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || memif_we !== 1'b1 || ldr_rvalid !== 1'b1 || ldr_rdata !== m_rd_l) begin
            errors++;
            $display("FAIL early_cpu: cpu=%b we=%b rvalid=%b rdata=%h, want 1 1 1 %h",
                     cpu_gnt, memif_we, ldr_rvalid, ldr_rdata, m_rd_l);
        end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ldr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL early_idle: ldr_rvalid=%b, want 0", ldr_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        cpu_req = 1'b0;
        ldr_req = 1'b1; ldr_burst = 1'b1; ldr_we = 1'b0; ldr_addr = $urandom & 32'h3FC;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (ldr_gnt !== 1'b1) begin
                errors++;
                $display("FAIL rmb_beat[%0d]: ldr_gnt=%b, want 1", k, ldr_gnt);
            end
            next_cycle();
            ldr_addr = $urandom & 32'h3FC;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ldr_gnt !== 1'b0 || memif_we !== 1'b0 || ldr_rvalid !== m_rv_l) begin
            errors++;
            $display("FAIL rmb_reset: ldr=%b we=%b rvalid=%b, want 0 0 %b",
                     ldr_gnt, memif_we, ldr_rvalid, m_rv_l);
        end
        next_cycle();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = $urandom & 32'h3FC;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0 || ldr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rmb_release: cpu=%b ldr=%b rvalid=%b, want 1 0 0",
                     cpu_gnt, ldr_gnt, ldr_rvalid);
        end
        next_cycle();
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ldr_rvalid !== 1'b0 || cpu_rvalid !== 1'b1 || cpu_rdata !== m_rd_c) begin
            errors++;
            $display("FAIL rmb_after: ldr_rvalid=%b cpu_rvalid=%b rdata=%h, want 0 1 %h",
                     ldr_rvalid, cpu_rvalid, cpu_rdata, m_rd_c);
        end
        next_cycle();
    endtask

    task automatic test_random();
        bit cg, lg;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            predict(cg, lg);
            checks++;
            if (cpu_gnt !== cg || ldr_gnt !== lg || cpu_stall !== (cpu_req && !cg)) begin
                errors++;
                $display("FAIL rand_gnt[%0d]: cpu=%b ldr=%b stall=%b, want %b %b %b", i,
                         cpu_gnt, ldr_gnt, cpu_stall, cg, lg, cpu_req && !cg);
            end
            checks++;
            if (memif_we !== ((cg && cpu_we) || (lg && ldr_we))) begin
                errors++;
                $display("FAIL rand_we[%0d]: we=%b, want %b", i, memif_we,
                         (cg && cpu_we) || (lg && ldr_we));
            end
            if (cg || lg) begin
                checks++;
                if (memif_addr !== (cg ? cpu_addr : ldr_addr) || memif_be !== (cg ? cpu_be : ldr_be) ||
                    memif_wdata !== (cg ? cpu_wdata : ldr_wdata)) begin
                    errors++;
                    $display("FAIL rand_bus[%0d]: addr=%h be=%h wdata=%h, want %h %h %h", i,
                             memif_addr, memif_be, memif_wdata, cg ? cpu_addr : ldr_addr,
                             cg ? cpu_be : ldr_be, cg ? cpu_wdata : ldr_wdata);
                end
            end
            checks++;
            if (cpu_rvalid !== m_rv_c || ldr_rvalid !== m_rv_l ||
                (m_rv_c && cpu_rdata !== m_rd_c) || (m_rv_l && ldr_rdata !== m_rd_l)) begin
                errors++;
                $display("FAIL rand_read[%0d]: c=%b/%h l=%b/%h, want %b/%h %b/%h", i,
                         cpu_rvalid, cpu_rdata, ldr_rvalid, ldr_rdata, m_rv_c, m_rd_c,
                         m_rv_l, m_rd_l);
            end
            next_cycle();
            reset = ($urandom_range(0, 59) != 0);
            if (!cpu_req || cg) begin
                cpu_req = ($urandom_range(0, 2) != 0);
                cpu_we = $urandom_range(0, 1);
                cpu_be = 4'($urandom);
                cpu_addr = $urandom & 32'h3FC;
                cpu_wdata = $urandom;
            end
            if (!ldr_req || lg) begin
                ldr_req = ($urandom_range(0, 2) != 0);
                ldr_we = $urandom_range(0, 1);
                ldr_be = 4'($urandom);
                ldr_addr = $urandom & 32'h3FC;
                ldr_wdata = $urandom;
                ldr_burst = ($urandom_range(0, 3) != 0);
            end
        end
        reset = 1'b1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            gold[i] = ram[i];
        end
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_be = 4'h0; ldr_addr = 32'h0; ldr_wdata = 32'h0;
        ldr_burst = 1'b0;
        m_burst = 1'b0; m_beats = 0; m_waits = 0; m_rv_c = 1'b0; m_rv_l = 1'b0;
        m_rd_c = 32'h0; m_rd_l = 32'h0;
        test_reset();
        test_cpu_read();
        test_conflict();
        test_burst();
        test_early_end();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
